peri_console_uart: RTL
======================

// Module: peri_console_uart
// PURPOSE
//  Memory-mapped console peripheral on the pico_top peri_* bus. It replaces the fixed print path with
//  parametrised TX/RX FIFOs, an internal 8N1 serializer and deserializer, a runtime baud divider, CTS flow
//  control and a status register. The CPU writes bytes to TXDATA and pops received bytes from RXDATA.
//  Sits beside memPkt and ORs its peri_ready/peri_rdata into the bus.
// PARAMETERS
//  BASE_ADDR    32'h1000_0000  register window base (16-byte window, word aligned)
//  TX_DEPTH     512            TX FIFO entries (power of 2, >=2)
//  RX_DEPTH     16             RX FIFO entries (power of 2, >=2)
//  DEFAULT_DIV  16'd868        clk cycles per bit after reset (100 MHz / 115200)
//  BLOCKING     1              1: stall a TXDATA write while the TX FIFO is full; 0: drop it and set TX_OVF
//  CTS_EN       0              1: start a TX frame only while uart_cts_i==0
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous active-low reset
//  peri_rden   in   1   read request, held until peri_ready
//  peri_wren   in   1   write request, held until peri_ready
//  peri_addr   in   32  byte address
//  peri_wdata  in   32  write data
//  peri_wstrb  in   4   byte strobes; a write with wstrb==0 completes with no effect
//  peri_rdata  out  32  read data, valid only while peri_ready=1, else 0
//  peri_ready  out  1   one-cycle completion pulse
//  uart_tx     out  1   serial out, idle 1
//  uart_rx     in   1   serial in (asynchronous)
//  uart_cts_i  in   1   clear-to-send, active low
//  irq_o       out  1   (RX FIFO not empty & RXIE) | any sticky error
// BEHAVIOUR
//  Reset: peri_ready=0, peri_rdata=0, uart_tx=1, irq_o=0; FIFOs empty; sticky bits 0; DIV=DEFAULT_DIV; RXIE=0.
//  Async reset mid-frame aborts the frame; uart_tx returns to 1 immediately.
//  Registers (offset from BASE_ADDR):
//    0x0 TXDATA  W: push wdata[7:0]; R: 0
//    0x4 RXDATA  R: {rx_valid,23'b0,byte} and pop if non-empty; empty -> 0, no pop
//    0x8 STATUS  R: [0]tx_full [1]tx_empty [2]rx_valid [3]tx_busy [4]TX_OVF [5]RX_OVF [6]FRAME_ERR
//                   [7]RXIE [31:16]tx_count (saturates at 16'hFFFF)
//                W: 1s on [6:4] clear those sticky bits; [7] writes RXIE
//    0xC DIV     R/W: [15:0]; writes of 0 or 1 are stored as 2; takes effect at the next frame start
//  Handshake: a request is accepted when (rden|wren), the address lies in the window and busy=0.
//    peri_ready pulses exactly 1 cycle later (registered). busy=1 during the ready cycle and the cycle after,
//    so one held request is never double-accepted. Out-of-window addresses get no response.
//    rden and wren together: the write wins.
//  TXDATA while full: BLOCKING=1 -> no accept; the request waits and completes after a slot frees.
//    BLOCKING=0 -> accept, drop the byte, set TX_OVF.
//  TX FSM: IDLE -> START(1 bit, tx=0) -> DATA(8 bits, LSB first) -> STOP(1 bit, tx=1) -> IDLE.
//    IDLE leaves when the FIFO is non-empty (and CTS low if CTS_EN); the byte pops on that cycle.
//    Each bit lasts exactly DIV cycles. Back-to-back frames have no idle gap.
//    CTS is sampled only in IDLE; its deassertion mid-frame does not abort the frame.
//    tx_busy = state!=IDLE.
//  RX FSM: 2-flop synchroniser. IDLE -> START when a falling edge is seen.
//    START: re-sample at DIV/2; if the line is high, treat it as a glitch and return to IDLE.
//    DATA: 8 samples at DIV spacing. STOP: a sample of 0 sets FRAME_ERR and discards the byte;
//    a sample of 1 pushes the byte. Push into a full RX FIFO drops the byte and sets RX_OVF.
//  FIFO push and pop in the same cycle are both honoured, including when full (TX) or empty (RX, no pop).
//  FIFO pointers wrap modulo depth; count width is $clog2(depth)+1.
//  An RX push and a CPU STATUS clear in the same cycle: the set wins.
// TESTING
//  1 Reset, read STATUS -> 32'h0000_0002; uart_tx=1; DIV reads 868.
//  2 DIV=4, write 8'h55 -> peri_ready 1 cycle after accept; tx line 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
//  3 TX_DEPTH=4, BLOCKING=1, CTS held high with CTS_EN=1: 5th write stalls; drop CTS -> write completes.
//  4 BLOCKING=0, same fill: 5th write acks, STATUS[4]=1; write 32'h10 to STATUS -> bit clears.
//  5 Drive RX 8'hA3 at DIV=8, then bad stop bit: RXDATA=32'h8000_00A3; FRAME_ERR=1; 2nd read -> 0.
//  6 RX_DEPTH=2, send 3 bytes, RXIE=1 -> irq_o=1, RX_OVF=1, first two bytes read back in order.

Source files
------------

// File: rtl/peri_console_uart.sv
// Console UART peripheral on the peri_* bus.
// TX/RX FIFOs, 8N1 serializer/deserializer, runtime baud divider, CTS, status.
module peri_console_uart #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          TX_DEPTH    = 512,
    parameter int          RX_DEPTH    = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter bit          BLOCKING    = 1'b1,
    parameter bit          CTS_EN      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        peri_rden,
    input  logic        peri_wren,
    input  logic [31:0] peri_addr,
    input  logic [31:0] peri_wdata,
    input  logic [3:0]  peri_wstrb,
    output logic [31:0] peri_rdata,
    output logic        peri_ready,
    output logic        uart_tx,
    input  logic        uart_rx,
    input  logic        uart_cts_i,
    output logic        irq_o
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;
    localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic           ready_q, busy_q;
    logic [31:0]    rdata_q, rdata_d;
    logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
    logic           tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic           ferr_q, ferr_d, rxie_q, rxie_d;
    logic [15:0]    div_q, div_d;
    state_e         ts_q, ts_d, rs_q, rs_d;
    logic [15:0]    tdiv_q, tdiv_d, ttick_q, ttick_d;
    logic [15:0]    rdiv_q, rdiv_d, rtick_q, rtick_d;
    logic [2:0]     tbit_q, tbit_d, rbit_q, rbit_d;
    logic [7:0]     tsh_q, tsh_d, rsh_q, rsh_d;
    logic           tx_q, tx_d;
    logic           rs1_q, rs2_q, rprev_q;

    logic        in_win, busy, accept, stall, is_tx_wr, wr_any;
    logic        tx_full, tx_empty, rx_valid, rx_full, cts_ok;
    logic        tx_push, tx_pop, rx_push, rx_pop, rx_req, ferr_set;
    logic [1:0]  off;
    logic [15:0] tx_cnt16;
    logic [31:0] tx_cnt32, status;
    logic        unused_ok;

    assign unused_ok = ^{peri_addr[1:0], peri_wdata[31:16]};
    assign in_win    = peri_addr[31:4] == BASE_ADDR[31:4];
    assign off       = peri_addr[3:2];
    assign busy      = ready_q | busy_q;
    assign tx_full   = tx_cnt_q == TX_FULL;
    assign tx_empty  = tx_cnt_q == '0;
    assign rx_full   = rx_cnt_q == RX_FULL;
    assign rx_valid  = rx_cnt_q != '0;
    assign cts_ok    = !CTS_EN || !uart_cts_i;
    assign wr_any    = peri_wren & (|peri_wstrb);
    assign is_tx_wr  = wr_any & (off == 2'd0);
    assign stall     = BLOCKING & is_tx_wr & tx_full & ~tx_pop;
    assign accept    = (peri_rden | peri_wren) & in_win & ~busy & ~stall;
    assign tx_push   = accept & is_tx_wr & (~tx_full | tx_pop);
    assign rx_pop    = accept & ~peri_wren & (off == 2'd1) & rx_valid;
    assign rx_push   = rx_req & (~rx_full | rx_pop);
    assign tx_cnt32  = 32'(tx_cnt_q);
    assign tx_cnt16  = (tx_cnt32 > 32'hFFFF) ? 16'hFFFF : tx_cnt32[15:0];
    assign status    = {tx_cnt16, 8'h00, rxie_q, ferr_q, rx_ovf_q,
                        tx_ovf_q, ts_q != S_IDLE, rx_valid, tx_empty, tx_full};

    assign peri_ready = ready_q;
    assign peri_rdata = rdata_q;
    assign uart_tx    = tx_q;
    assign irq_o      = (rx_valid & rxie_q) | tx_ovf_q | rx_ovf_q | ferr_q;

    // Register file: read mux, config writes, sticky bits and FIFO pointers
    always_comb begin
        rdata_d  = '0;
        div_d    = div_q;
        rxie_d   = rxie_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        ferr_d   = ferr_q;
        if (accept && !peri_wren) begin
            case (off)
                2'd1:    rdata_d = rx_valid ? {1'b1, 23'd0, rx_mem[rx_rp_q]} : '0;
                2'd2:    rdata_d = status;
                2'd3:    rdata_d = {16'd0, div_q};
                default: rdata_d = '0;
            endcase
        end
        if (accept && wr_any && off == 2'd2) begin
            tx_ovf_d = tx_ovf_d & ~peri_wdata[4];
            rx_ovf_d = rx_ovf_d & ~peri_wdata[5];
            ferr_d   = ferr_d & ~peri_wdata[6];
            rxie_d   = peri_wdata[7];
        end
        if (accept && wr_any && off == 2'd3)
            div_d = (peri_wdata[15:0] < 16'd2) ? 16'd2 : peri_wdata[15:0];
        // hardware set has priority over a simultaneous CPU clear
        if (accept && is_tx_wr && tx_full && !tx_pop) tx_ovf_d = 1'b1;
        if (rx_req && rx_full && !rx_pop)             rx_ovf_d = 1'b1;
        if (ferr_set)                                 ferr_d   = 1'b1;
        tx_wp_d  = tx_wp_q + TAW'(tx_push);
        tx_rp_d  = tx_rp_q + TAW'(tx_pop);
        tx_cnt_d = tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
        rx_wp_d  = rx_wp_q + RAW'(rx_push);
        rx_rp_d  = rx_rp_q + RAW'(rx_pop);
        rx_cnt_d = rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
    end

    // TX framer: start bit, 8 data bits LSB first, stop bit, no gap between frames
    always_comb begin
        ts_d = ts_q; tdiv_d = tdiv_q; ttick_d = ttick_q + 16'd1;
        tbit_d = tbit_q; tsh_d = tsh_q; tx_d = tx_q; tx_pop = 1'b0;
        unique case (ts_q)
            S_IDLE: begin
                tx_d = 1'b1;
                ttick_d = '0;
                if (!tx_empty && cts_ok) begin
                    tx_pop = 1'b1; ts_d = S_START; tx_d = 1'b0;
                    tsh_d = tx_mem[tx_rp_q]; tdiv_d = div_q;
                end
            end
            S_START: if (ttick_q == tdiv_q - 16'd1) begin
                ts_d = S_DATA; tx_d = tsh_q[0]; ttick_d = '0; tbit_d = '0;
            end
            S_DATA: if (ttick_q == tdiv_q - 16'd1) begin
                ttick_d = '0;
                if (tbit_q == 3'd7) begin
                    ts_d = S_STOP; tx_d = 1'b1;
                end else begin
                    tsh_d = tsh_q >> 1; tx_d = tsh_q[1]; tbit_d = tbit_q + 3'd1;
                end
            end
            S_STOP: if (ttick_q == tdiv_q - 16'd1) begin
                ttick_d = '0;
                if (!tx_empty && cts_ok) begin
                    tx_pop = 1'b1; ts_d = S_START; tx_d = 1'b0;
                    tsh_d = tx_mem[tx_rp_q]; tdiv_d = div_q;
                end else begin
                    ts_d = S_IDLE; tx_d = 1'b1;
                end
            end
        endcase
    end

    // RX deframer: mid-bit sampling from the start edge, glitch reject, stop check
    always_comb begin
        rs_d = rs_q; rdiv_d = rdiv_q; rtick_d = rtick_q + 16'd1;
        rbit_d = rbit_q; rsh_d = rsh_q; rx_req = 1'b0; ferr_set = 1'b0;
        unique case (rs_q)
            S_IDLE: begin
                rtick_d = '0;
                if (rprev_q && !rs2_q) begin
                    rs_d = S_START; rdiv_d = div_q;
                end
            end
            S_START: if (rtick_q == (rdiv_q >> 1) - 16'd1) begin
                rtick_d = '0; rbit_d = '0;
                rs_d = rs2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rtick_q == rdiv_q - 16'd1) begin
                rtick_d = '0;
                rsh_d = {rs2_q, rsh_q[7:1]};
                rbit_d = rbit_q + 3'd1;
                if (rbit_q == 3'd7) rs_d = S_STOP;
            end
            S_STOP: if (rtick_q == rdiv_q - 16'd1) begin
                rs_d = S_IDLE;
                if (rs2_q) rx_req = 1'b1;
                else       ferr_set = 1'b1;
            end
        endcase
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= peri_wdata[7:0];
        if (rx_push) rx_mem[rx_wp_q] <= rsh_q;
    end

    // All control state, including both FSMs and the registered bus response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0; busy_q <= 1'b0; rdata_q <= '0;
            tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
            rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0; rx_ovf_q <= 1'b0; ferr_q <= 1'b0; rxie_q <= 1'b0;
            div_q <= DEFAULT_DIV;
            ts_q <= S_IDLE; tdiv_q <= DEFAULT_DIV; ttick_q <= '0;
            tbit_q <= '0; tsh_q <= '0; tx_q <= 1'b1;
            rs_q <= S_IDLE; rdiv_q <= DEFAULT_DIV; rtick_q <= '0;
            rbit_q <= '0; rsh_q <= '0;
            rs1_q <= 1'b1; rs2_q <= 1'b1; rprev_q <= 1'b1;
        end else begin
            ready_q <= accept; busy_q <= ready_q; rdata_q <= rdata_d;
            tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; tx_cnt_q <= tx_cnt_d;
            rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d; rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d; rx_ovf_q <= rx_ovf_d;
            ferr_q <= ferr_d; rxie_q <= rxie_d; div_q <= div_d;
            ts_q <= ts_d; tdiv_q <= tdiv_d; ttick_q <= ttick_d;
            tbit_q <= tbit_d; tsh_q <= tsh_d; tx_q <= tx_d;
            rs_q <= rs_d; rdiv_q <= rdiv_d; rtick_q <= rtick_d;
            rbit_q <= rbit_d; rsh_q <= rsh_d;
            rs1_q <= uart_rx; rs2_q <= rs1_q; rprev_q <= rs2_q;
        end
    end
endmodule
